// File: rtl/vga_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vga_mode_sequencer
// Description : Raster timing generator and display-mode scheduler for a
//               640x480@60 VGA path running on the 25 MHz pixel clock.
//               Produces sync, data-enable and pixel coordinates, and picks
//               the pattern mode.  A mode change takes effect only at a frame
//               boundary, so every frame is rendered in a single mode.
//
// Ports       : clk            pixel clock
//               rst            synchronous active-high reset
//               mode_next_i    request to advance to the next mode (pulse/level)
//               auto_en_i      advance automatically every FRAMES_PER_MODE frames
//               hs_n_o         horizontal sync, active low
//               vs_n_o         vertical sync, active low
//               de_o           display enable, high on visible pixels
//               x_o, y_o       pixel column/row, aligned with de_o
//               mode_o         current pattern mode, 0..NUM_MODES-1
//               frame_start_o  one-cycle pulse when (0,0) is presented
//               mode_changed_o one-cycle pulse with the first frame_start
//                              of a new mode
// Revision    : 1.0  initial release
// ============================================================================
module vga_mode_sequencer #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int NUM_MODES       = 3,
    parameter int FRAMES_PER_MODE = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_next_i,
    input  logic       auto_en_i,
    output logic       hs_n_o,
    output logic       vs_n_o,
    output logic       de_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic [1:0] mode_o,
    output logic       frame_start_o,
    output logic       mode_changed_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END   = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] MODE_LAST   = 2'(NUM_MODES - 1);

    // Frame counter only needs to reach FRAMES_PER_MODE-1; keep at least 1 bit.
    localparam int               FCW     = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [FCW-1:0]   FC_LAST = FCW'(FRAMES_PER_MODE - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state_q,        state_d;
    logic [9:0]       hcnt_q,         hcnt_d;
    logic [9:0]       vcnt_q,         vcnt_d;
    logic [FCW-1:0]   fcnt_q,         fcnt_d;
    logic [1:0]       mode_q,         mode_d;
    logic             adv_q,          adv_d;
    logic [9:0]       x_q,            x_d;
    logic [9:0]       y_q,            y_d;
    logic             de_q,           de_d;
    logic             hs_n_q,         hs_n_d;
    logic             vs_n_q,         vs_n_d;
    logic             frame_start_q,  frame_start_d;
    logic             mode_changed_q, mode_changed_d;

    logic w_h_last;
    logic w_boundary;
    logic w_auto_due;
    logic w_advance;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        hcnt_d         = hcnt_q;
        vcnt_d         = vcnt_q;
        fcnt_d         = fcnt_q;
        mode_d         = mode_q;

        w_h_last   = (hcnt_q == H_LAST);
        w_boundary = w_h_last && (vcnt_q == V_LAST);
        w_auto_due = auto_en_i && (fcnt_q == FC_LAST);
        // A request seen in the boundary cycle itself counts, so a level held
        // high yields exactly one advance per frame.
        w_advance  = w_boundary &&
                     ((state_q == ST_PENDING) || mode_next_i || w_auto_due);
        adv_d      = w_advance;

        // Raster counters
        if (w_h_last) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end else begin
            hcnt_d = hcnt_q + 10'd1;
        end

        // Mode FSM: one latched request, no queuing beyond that.
        case (state_q)
            ST_RUN: begin
                if (mode_next_i && !w_boundary) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_boundary) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (w_advance) begin
            mode_d = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;
        end

        // Frame counter: cleared while auto is off or on an advance; it can
        // never pass FC_LAST because reaching it forces an advance.
        if (!auto_en_i || w_advance) begin
            fcnt_d = '0;
        end else if (w_boundary && (fcnt_q != FC_LAST)) begin
            fcnt_d = fcnt_q + 1'b1;
        end

        // Registered video outputs, one cycle behind the counters.
        x_d            = hcnt_q;
        y_d            = vcnt_q;
        de_d           = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
        hs_n_d         = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
        vs_n_d         = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
        frame_start_d  = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
        // adv_q is only ever set in the cycle the counters sit at (0,0).
        mode_changed_d = adv_q;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            hcnt_q         <= '0;
            vcnt_q         <= '0;
            fcnt_q         <= '0;
            mode_q         <= '0;
            adv_q          <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            de_q           <= 1'b0;
            hs_n_q         <= 1'b1;
            vs_n_q         <= 1'b1;
            frame_start_q  <= 1'b0;
            mode_changed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hcnt_q         <= hcnt_d;
            vcnt_q         <= vcnt_d;
            fcnt_q         <= fcnt_d;
            mode_q         <= mode_d;
            adv_q          <= adv_d;
            x_q            <= x_d;
            y_q            <= y_d;
            de_q           <= de_d;
            hs_n_q         <= hs_n_d;
            vs_n_q         <= vs_n_d;
            frame_start_q  <= frame_start_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    assign hs_n_o         = hs_n_q;
    assign vs_n_o         = vs_n_q;
    assign de_o           = de_q;
    assign x_o            = x_q;
    assign y_o            = y_q;
    assign mode_o         = mode_q;
    assign frame_start_o  = frame_start_q;
    assign mode_changed_o = mode_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_mode_sequencer
// Description : Directed self-checking bench for vga_mode_sequencer using a
//               reduced raster (16x10 total, 8x6 visible) so that many frames
//               fit in a short run.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_mode_sequencer;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = 16;
    localparam int V_TOTAL  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_next_i;
    logic       auto_en_i;
    logic       hs_n_o;
    logic       vs_n_o;
    logic       de_o;
    logic [9:0] x_o;
    logic [9:0] y_o;
    logic [1:0] mode_o;
    logic       frame_start_o;
    logic       mode_changed_o;

    int total = 0;
    int bad   = 0;

    vga_mode_sequencer #(
        .H_ACTIVE        (H_ACTIVE),
        .H_FP            (H_FP),
        .H_SYNC          (H_SYNC),
        .H_BP            (H_BP),
        .V_ACTIVE        (V_ACTIVE),
        .V_FP            (V_FP),
        .V_SYNC          (V_SYNC),
        .V_BP            (V_BP),
        .NUM_MODES       (3),
        .FRAMES_PER_MODE (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode_next_i    (mode_next_i),
        .auto_en_i      (auto_en_i),
        .hs_n_o         (hs_n_o),
        .vs_n_o         (vs_n_o),
        .de_o           (de_o),
        .x_o            (x_o),
        .y_o            (y_o),
        .mode_o         (mode_o),
        .frame_start_o  (frame_start_o),
        .mode_changed_o (mode_changed_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample point 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance at least one cycle until the outputs present (xx,yy).
    task automatic wait_xy(input int xx, input int yy);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!((x_o == 10'(xx)) && (y_o == 10'(yy))) && (n < 4000));
        if (n >= 4000) begin
            total++;
            bad++;
            $error("FAIL wait_xy timeout observed=(%0d,%0d) expected=(%0d,%0d)",
                   x_o, y_o, xx, yy);
        end
    endtask

    // Single-cycle request mid-frame, then check the new frame.
    task automatic manual_advance(input int exp_mode);
        wait_xy(0, 3);
        mode_next_i = 1'b1;
        step();
        mode_next_i = 1'b0;
        wait_xy(0, 0);
        check("adv_mode", mode_o, exp_mode);
        check("adv_changed", mode_changed_o, 1);
    endtask

    initial begin
        int de_cnt, hs_cnt, vs_cnt, fs_cnt, x_max, y_max, hs_first, vs_first;

        rst         = 1'b1;
        mode_next_i = 1'b0;
        auto_en_i   = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_hs_n", hs_n_o, 1);
        check("rst_vs_n", vs_n_o, 1);
        check("rst_de", de_o, 0);
        check("rst_x", x_o, 0);
        check("rst_y", y_o, 0);
        check("rst_fs", frame_start_o, 0);
        check("rst_mc", mode_changed_o, 0);
        check("rst_mode", mode_o, 0);

        rst = 1'b0;
        step();
        check("first_fs", frame_start_o, 1);
        check("first_de", de_o, 1);
        check("first_x", x_o, 0);
        check("first_y", y_o, 0);

        // ---------------- two full frames of raster timing ----------------
        for (int f = 0; f < 2; f++) begin
            de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
            x_max = 0; y_max = 0; hs_first = -1; vs_first = -1;
            for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
                if (de_o) de_cnt++;
                if (!hs_n_o) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(x_o);
                end
                if (!vs_n_o) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = int'(y_o);
                end
                if (frame_start_o) fs_cnt++;
                if (int'(x_o) > x_max) x_max = int'(x_o);
                if (int'(y_o) > y_max) y_max = int'(y_o);
                step();
            end
            check("de_count", de_cnt, 48);
            check("hs_low_count", hs_cnt, 30);
            check("hs_first_x", hs_first, 10);
            check("vs_low_count", vs_cnt, 32);
            check("vs_first_y", vs_first, 7);
            check("fs_per_frame", fs_cnt, 1);
            check("x_max", x_max, 15);
            check("y_max", y_max, 9);
            check("fs_period", frame_start_o, 1);
            check("idle_mode", mode_o, 0);
        end

        // ---------------- single mid-frame request ----------------
        wait_xy(0, 3);
        mode_next_i = 1'b1;
        step();
        mode_next_i = 1'b0;
        // extra requests in the same frame must not queue
        wait_xy(4, 4);
        mode_next_i = 1'b1;
        step();
        mode_next_i = 1'b0;
        wait_xy(2, 5);
        mode_next_i = 1'b1;
        step();
        mode_next_i = 1'b0;
        wait_xy(14, 9);
        check("pend_mode_before", mode_o, 0);
        step();
        check("pend_mode_edge", mode_o, 1);
        check("pend_mc_early", mode_changed_o, 0);
        step();
        check("pend_fs", frame_start_o, 1);
        check("pend_mc", mode_changed_o, 1);
        check("pend_mode", mode_o, 1);
        step();
        check("pend_mc_pulse", mode_changed_o, 0);
        wait_xy(0, 0);
        check("no_queue_mode", mode_o, 1);
        check("no_queue_mc", mode_changed_o, 0);

        // ---------------- wrap through all modes ----------------
        manual_advance(2);
        manual_advance(0);

        // ---------------- automatic advance ----------------
        wait_xy(0, 1);
        auto_en_i = 1'b1;
        wait_xy(0, 0);
        check("auto_f1_mode", mode_o, 0);
        check("auto_f1_mc", mode_changed_o, 0);
        wait_xy(0, 0);
        check("auto_f2_mode", mode_o, 1);
        check("auto_f2_mc", mode_changed_o, 1);
        wait_xy(0, 0);
        check("auto_f3_mode", mode_o, 1);
        check("auto_f3_mc", mode_changed_o, 0);
        wait_xy(0, 0);
        check("auto_f4_mode", mode_o, 2);
        check("auto_f4_mc", mode_changed_o, 1);
        // frame counter is 1 after this frame; drop auto for the next frame
        wait_xy(0, 0);
        check("drop_mode0", mode_o, 2);
        wait_xy(0, 1);
        auto_en_i = 1'b0;
        wait_xy(0, 0);
        check("drop_mode1", mode_o, 2);
        wait_xy(0, 1);
        auto_en_i = 1'b1;
        wait_xy(0, 0);
        check("restart_mode", mode_o, 2);
        check("restart_mc", mode_changed_o, 0);
        wait_xy(0, 0);
        check("restart_adv_mode", mode_o, 0);
        check("restart_adv_mc", mode_changed_o, 1);

        // ---------------- manual request in the boundary cycle with auto due --
        wait_xy(0, 0);
        check("coinc_pre_mode", mode_o, 0);
        // outputs at (14,9) means the counters sit at the boundary cycle
        wait_xy(14, 9);
        mode_next_i = 1'b1;
        step();
        mode_next_i = 1'b0;
        check("coinc_mode", mode_o, 1);
        step();
        check("coinc_mc", mode_changed_o, 1);
        wait_xy(0, 0);
        check("coinc_next_mode", mode_o, 1);
        check("coinc_next_mc", mode_changed_o, 0);

        // ---------------- reset while a request is pending ----------------
        auto_en_i = 1'b0;
        wait_xy(0, 2);
        mode_next_i = 1'b1;
        step();
        mode_next_i = 1'b0;
        wait_xy(5, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_hs_n", hs_n_o, 1);
        check("mid_rst_vs_n", vs_n_o, 1);
        check("mid_rst_de", de_o, 0);
        check("mid_rst_mode", mode_o, 0);
        step();
        check("mid_rst_fs", frame_start_o, 1);
        check("mid_rst_x", x_o, 0);
        check("mid_rst_y", y_o, 0);
        wait_xy(0, 0);
        check("mid_rst_no_adv_mode", mode_o, 0);
        check("mid_rst_no_adv_mc", mode_changed_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
